// File: rtl/fcvt_iter.sv
// Iterative single-precision float<->int32 converter sharing one small shift stage.
// Latency: specials 1 cycle to out_valid; otherwise SHIFT cycles + ROUND + DONE (STEP=1: ftoi k+2, itof lz+2).
// Backpressure: accepts only in IDLE; result held in DONE until out_ready, no accept in that cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   op, x               0 = ftoi, 1 = itof; operand; both sampled on accept
//   out_valid/out_ready result handshake
//   y                   registered result
//   ovf                 ftoi out-of-range/NaN/Inf flag, present only when FCVT_OVF_FLAG_EN is defined
// Parameter STEP (1, 2, 4, 8): maximum bits shifted per SHIFT cycle.
module fcvt_iter #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef FCVT_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] r_q, r_d;       // ftoi: mantissa being right-shifted; itof: magnitude being normalised
  logic [4:0]  cnt_q, cnt_d;   // ftoi remaining right-shift
  logic [7:0]  expo_q, expo_d; // itof biased exponent
  logic [31:0] y_q, y_d;
`ifdef FCVT_OVF_FLAG_EN
  logic        ovf_q, ovf_d;
`endif

  logic [7:0]  e;
  logic [31:0] a_abs;
  logic [4:0]  sh;
  logic [31:0] r_sh;
  logic [31:0] mag;
  logic [23:0] frac;  // {carry out of the hidden bit, 23-bit fraction}

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign_d  = sign_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    expo_d  = expo_q;
    y_d     = y_q;
`ifdef FCVT_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    e     = x[30:23];
    // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
    a_abs = x[31] ? (~x + 32'd1) : x;

    // Shift by min(STEP, remaining) using only the STEP small fixed shifts.
    sh   = (cnt_q < STEP_W) ? cnt_q : STEP_W;
    r_sh = r_q;
    for (int i = 1; i <= STEP; i++) begin
      if (sh == 5'(i)) r_sh = r_q >> i;
    end

    // (r+1)>>1 without a 33-bit adder: half away from zero on the magnitude.
    mag  = {1'b0, r_q[31:1]} + {31'd0, r_q[0]};
    // Ties round up with no sticky bit, e.g. 2^24+1 -> 0x4B800001.
    frac = {1'b0, r_q[30:8]} + {23'd0, r_q[7]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          sign_d = x[31];
`ifdef FCVT_OVF_FLAG_EN
          ovf_d  = 1'b0;
`endif
          if (!op) begin
            if (e < 8'd126) begin
              y_d     = 32'd0;
              state_d = DONE;
            end else if (e >= 8'd158) begin
              // Saturate; -2^31 is exactly representable so it is not flagged.
              y_d     = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              state_d = DONE;
`ifdef FCVT_OVF_FLAG_EN
              ovf_d   = (x != 32'hCF00_0000);
`endif
            end else begin
              r_d     = {1'b1, x[22:0], 8'd0};
              cnt_d   = 5'(8'd157 - e);
              state_d = (e == 8'd157) ? ROUND : SHIFT;
            end
          end else begin
            if (x == 32'd0) begin
              y_d     = 32'd0;
              state_d = DONE;
            end else begin
              r_d     = a_abs;
              expo_d  = 8'd158;
              state_d = a_abs[31] ? ROUND : SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        if (!op_q) begin
          r_d   = r_sh;
          cnt_d = cnt_q - sh;
          if (cnt_q == sh) state_d = ROUND;
        end else begin
          if (~|r_q[31 -: STEP]) begin
            r_d    = r_q << STEP;
            expo_d = expo_q - 8'(STEP);
          end else begin
            r_d    = r_q << 1;
            expo_d = expo_q - 8'd1;
          end
          if (r_d[31]) state_d = ROUND;
        end
      end
      ROUND: begin
        if (!op_q) begin
          y_d = sign_q ? (~mag + 32'd1) : mag;
        end else begin
          // On carry frac[22:0] is zero, so only the exponent bumps.
          y_d = {sign_q, expo_q + {7'd0, frac[23]}, frac[22:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      sign_q  <= 1'b0;
      r_q     <= 32'd0;
      cnt_q   <= 5'd0;
      expo_q  <= 8'd0;
      y_q     <= 32'd0;
`ifdef FCVT_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      expo_q  <= expo_d;
      y_q     <= y_d;
`ifdef FCVT_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
`ifdef FCVT_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule
